// File: rtl/access_sched_seq_pkg.sv
// Shared definitions for the access scheduler: FSM encoding and sizing helper.
package access_sched_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SCHED = 1'b1
    } sched_state_t;

    // Round counter must hold every round index of a group plus one spare bit.
    function automatic int rnd_width_for(input int group_size);
        return $clog2(group_size) + 1;
    endfunction

endpackage

// File: rtl/access_sched_seq_if.sv
// Request/issue bundle between the request generator, the scheduler and the port muxes.
interface access_sched_seq_if
    import access_sched_seq_pkg::*;
#(
    parameter int SHARED_GROUP_SIZE = 4,
    parameter int ADDR_WIDTH        = 8,
    parameter int RND_WIDTH         = rnd_width_for(SHARED_GROUP_SIZE)
);
    logic                                    rqst_valid;
    logic                                    rqst_ready;
    logic [SHARED_GROUP_SIZE-1:0]            rqst_in;
    logic [SHARED_GROUP_SIZE*ADDR_WIDTH-1:0] rqst_addr_in;
    logic                                    issue_stall;
    logic [SHARED_GROUP_SIZE-1:0]            issue_en;
    logic [SHARED_GROUP_SIZE*ADDR_WIDTH-1:0] issue_addr;
    logic [RND_WIDTH-1:0]                    issue_round;
    logic                                    sched_done;

    // Request source and downstream port side.
    modport master (
        output rqst_valid, rqst_in, rqst_addr_in, issue_stall,
        input  rqst_ready, issue_en, issue_addr, issue_round, sched_done
    );

    // Scheduler side.
    modport slave (
        input  rqst_valid, rqst_in, rqst_addr_in, issue_stall,
        output rqst_ready, issue_en, issue_addr, issue_round, sched_done
    );
endinterface

// File: rtl/access_sched_seq_sched_issue_mask.sv
// Neighbour-exclusion chain: picks pending requesters so no two adjacent ones
// (which share a bank port) are issued together. Lowest index wins greedily.
module sched_issue_mask #(
    parameter int SHARED_GROUP_SIZE = 4
) (
    input  logic [SHARED_GROUP_SIZE-1:0] pend,
    output logic [SHARED_GROUP_SIZE-1:0] mask
);

    // Ripple from requester 0 upward; a bit is taken unless its lower neighbour was.
    always_comb begin
        // NOTE: every output gets a default before any conditional write so no latch is inferred.
        mask    = '0;
        mask[0] = pend[0];
        for (int i = 1; i < SHARED_GROUP_SIZE; i++) begin
            mask[i] = pend[i] & ~mask[i-1];
        end
    end

endmodule

// File: rtl/access_sched_seq.sv
// Multi-cycle access scheduler: latches one request vector and serialises it
// into conflict-free issue rounds, retrying losers until nothing is pending.
module access_sched_seq
    import access_sched_seq_pkg::*;
#(
    parameter int SHARED_GROUP_SIZE = 4,
    parameter int ADDR_WIDTH        = 8,
    parameter int RND_WIDTH         = rnd_width_for(SHARED_GROUP_SIZE)
) (
    input logic              sys_clk,
    input logic              rst,
    access_sched_seq_if.slave bus
);

    localparam int AW_TOTAL = SHARED_GROUP_SIZE * ADDR_WIDTH;

    sched_state_t                 state_q, state_d;
    logic [SHARED_GROUP_SIZE-1:0] pend_q, pend_d;
    logic [AW_TOTAL-1:0]          addr_q, addr_d;
    logic [RND_WIDTH-1:0]         rnd_q, rnd_d;
    logic [SHARED_GROUP_SIZE-1:0] issue_en_q, issue_en_d;
    logic [AW_TOTAL-1:0]          issue_addr_q, issue_addr_d;
    logic [RND_WIDTH-1:0]         issue_round_q, issue_round_d;
    logic                         sched_done_q, sched_done_d;
    logic                         rqst_ready_q, rqst_ready_d;

    logic [SHARED_GROUP_SIZE-1:0] mask;
    logic [SHARED_GROUP_SIZE-1:0] pend_rem;
    logic                         accept;

    sched_issue_mask #(
        .SHARED_GROUP_SIZE(SHARED_GROUP_SIZE)
    ) u_mask (
        .pend(pend_q),
        .mask(mask)
    );

    assign pend_rem = pend_q & ~mask;
    assign accept   = (state_q == IDLE) && bus.rqst_valid && rqst_ready_q;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE only for a non-empty vector, return once the last round issues.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (bus.rqst_in != '0)) state_d = SCHED;
            SCHED:   if (!bus.issue_stall && (pend_rem == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath: latch on accept, issue one round per unstalled SCHED cycle.
    always_comb begin
        pend_d        = pend_q;
        addr_d        = addr_q;
        rnd_d         = rnd_q;
        issue_round_d = issue_round_q;
        issue_en_d    = '0;
        issue_addr_d  = '0;
        sched_done_d  = 1'b0;
        if (accept) begin
            pend_d        = bus.rqst_in;
            addr_d        = bus.rqst_addr_in;
            rnd_d         = '0;
            issue_round_d = '0;
            sched_done_d  = (bus.rqst_in == '0);
        end else if ((state_q == SCHED) && !bus.issue_stall) begin
            issue_en_d = mask;
            for (int i = 0; i < SHARED_GROUP_SIZE; i++) begin
                issue_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    mask[i] ? addr_q[i*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            end
            pend_d        = pend_rem;
            issue_round_d = rnd_q;
            rnd_d         = rnd_q + 1'b1;
            sched_done_d  = (pend_rem == '0);
        end
        // Ready stays low through the done pulse so a new vector never overlaps it.
        rqst_ready_d = (state_d == IDLE) && !sched_done_d;
    end

    // Pending, address and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pend_q        <= '0;
            // NOTE: the address store is reset too, so no stale page from an aborted vector survives reset.
            addr_q        <= '0;
            rnd_q         <= '0;
            issue_en_q    <= '0;
            issue_addr_q  <= '0;
            issue_round_q <= '0;
            sched_done_q  <= 1'b0;
            rqst_ready_q  <= 1'b1;
        end else begin
            pend_q        <= pend_d;
            addr_q        <= addr_d;
            rnd_q         <= rnd_d;
            issue_en_q    <= issue_en_d;
            issue_addr_q  <= issue_addr_d;
            issue_round_q <= issue_round_d;
            sched_done_q  <= sched_done_d;
            rqst_ready_q  <= rqst_ready_d;
        end
    end

    assign bus.rqst_ready  = rqst_ready_q;
    assign bus.issue_en    = issue_en_q;
    assign bus.issue_addr  = issue_addr_q;
    assign bus.issue_round = issue_round_q;
    assign bus.sched_done  = sched_done_q;

endmodule

// File: tb/tb_access_sched_seq.sv
// Directed bench for access_sched_seq: stimulus pushes hand-computed issue
// events (with their expected cycle) into a queue; a monitor pops and compares.
module tb_access_sched_seq;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    typedef struct {
        int          at;
        logic [3:0]  en;
        logic [31:0] addr;
        logic [2:0]  rnd;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    access_sched_seq_if #(.SHARED_GROUP_SIZE(4), .ADDR_WIDTH(8), .RND_WIDTH(3)) bus ();

    access_sched_seq #(
        .SHARED_GROUP_SIZE(4),
        .ADDR_WIDTH(8),
        .RND_WIDTH(3)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_issue(input int at, input logic [3:0] en, input logic [31:0] addr,
                                input logic [2:0] rnd, input logic done);
        exp_t e;
        e.at = at; e.en = en; e.addr = addr; e.rnd = rnd; e.done = done;
        exp_q.push_back(e);
    endtask

    // Any non-idle output must match the next queued expectation, including its cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (bus.issue_en != '0 || bus.sched_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {27'd0, bus.issue_en, bus.sched_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_cycle", cyc, e.at);
                    check("issue_en", {28'd0, bus.issue_en}, {28'd0, e.en});
                    check("issue_addr", bus.issue_addr, e.addr);
                    check("sched_done", {31'd0, bus.sched_done}, {31'd0, e.done});
                    if (e.en != '0) check("issue_round", {29'd0, bus.issue_round}, {29'd0, e.rnd});
                end
            end
        end
    endtask

    // Waits (bounded) for ready, presents one vector for one cycle; returns accept cycle.
    task automatic send(input logic [3:0] v, input logic [31:0] a, output int t);
        int n = 0;
        while (!bus.rqst_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!bus.rqst_ready) check("ready_timeout", 32'd0, 32'd1);
        t = cyc;
        bus.rqst_valid   = 1'b1;
        bus.rqst_in      = v;
        bus.rqst_addr_in = a;
        @(posedge sys_clk); #1;
        bus.rqst_valid   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge sys_clk); #1;
    endtask

    initial begin
        int t;
        int n;
        bus.rqst_valid   = 1'b0;
        bus.rqst_in      = '0;
        bus.rqst_addr_in = '0;
        bus.issue_stall  = 1'b0;

        // Reset values.
        next_cycle(); next_cycle();
        check("rst_ready", {31'd0, bus.rqst_ready}, 32'd1);
        check("rst_issue_en", {28'd0, bus.issue_en}, 32'd0);
        check("rst_issue_addr", bus.issue_addr, 32'd0);
        check("rst_issue_round", {29'd0, bus.issue_round}, 32'd0);
        check("rst_sched_done", {31'd0, bus.sched_done}, 32'd0);
        rst = 1'b0;
        next_cycle();

        fork
            monitor();
        join_none

        // All four requesting: alternate bits over two rounds.
        send(4'b1111, 32'h13121110, t);
        expect_issue(t + 2, 4'b0101, 32'h00120010, 3'd0, 1'b0);
        expect_issue(t + 3, 4'b1010, 32'h13001100, 3'd1, 1'b1);
        check("ready_low_after_accept", {31'd0, bus.rqst_ready}, 32'd0);

        // Adjacent middle pair is split across rounds.
        send(4'b0110, 32'h23222120, t);
        expect_issue(t + 2, 4'b0010, 32'h00002100, 3'd0, 1'b0);
        expect_issue(t + 3, 4'b0100, 32'h00220000, 3'd1, 1'b1);

        // Non-adjacent pair completes in one round.
        send(4'b1001, 32'h33323130, t);
        expect_issue(t + 2, 4'b1001, 32'h33000030, 3'd0, 1'b1);

        // Empty vector: done next cycle, no issue, ready back a cycle later.
        send(4'b0000, 32'hAAAAAAAA, t);
        expect_issue(t + 1, 4'b0000, 32'h00000000, 3'd0, 1'b1);
        check("empty_ready_low", {31'd0, bus.rqst_ready}, 32'd0);
        next_cycle();
        check("empty_ready_back", {31'd0, bus.rqst_ready}, 32'd1);

        // Stall for three cycles after accept; stray valid pulses must be ignored.
        n = 0;
        while (!bus.rqst_ready && n < 50) begin next_cycle(); n++; end
        t = cyc;
        expect_issue(t + 5, 4'b0101, 32'h00420040, 3'd0, 1'b0);
        expect_issue(t + 6, 4'b1010, 32'h43004100, 3'd1, 1'b1);
        bus.rqst_valid   = 1'b1;
        bus.rqst_in      = 4'b1111;
        bus.rqst_addr_in = 32'h43424140;
        next_cycle();
        bus.issue_stall  = 1'b1;
        bus.rqst_in      = 4'b0001;
        bus.rqst_addr_in = 32'h000000EE;
        check("stall_ready_low", {31'd0, bus.rqst_ready}, 32'd0);
        next_cycle();
        bus.rqst_valid   = 1'b0;
        check("stall_no_issue", {28'd0, bus.issue_en}, 32'd0);
        next_cycle();
        bus.rqst_valid   = 1'b1;
        next_cycle();
        bus.issue_stall  = 1'b0;
        bus.rqst_valid   = 1'b0;

        // Reset during the second round: outputs clear at once, nothing more issues.
        send(4'b1111, 32'h63626160, t);
        expect_issue(t + 2, 4'b0101, 32'h00620060, 3'd0, 1'b0);
        next_cycle();
        @(negedge sys_clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_issue_en", {28'd0, bus.issue_en}, 32'd0);
        check("midrst_issue_addr", bus.issue_addr, 32'd0);
        check("midrst_round", {29'd0, bus.issue_round}, 32'd0);
        check("midrst_done", {31'd0, bus.sched_done}, 32'd0);
        check("midrst_ready", {31'd0, bus.rqst_ready}, 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle(); next_cycle();

        // Normal operation after the abort.
        send(4'b0001, 32'h00000050, t);
        expect_issue(t + 2, 4'b0001, 32'h00000050, 3'd0, 1'b1);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin next_cycle(); n++; end
        repeat (4) next_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/access_sched_seq.md
# access_sched_seq

Multi-cycle access scheduler directly downstream of the access-request generator in the memory-sharing path. Accepts one request vector per shared group (one bit plus page address per requester) and serialises it into conflict-free issue rounds. Adjacent requesters share a bank port, so two neighbours are never issued in the same cycle. Issued accesses drive the shared-memory port muxes; losers are retried in later rounds until the pending set is empty.

## Interface
Parameters:
- SHARED_GROUP_SIZE, 4, requesters per shared group (≥2)
- ADDR_WIDTH, 8, page address width per requester
- RND_WIDTH, 3, issue-round counter width; ≥ clog2(SHARED_GROUP_SIZE)+1

Ports:
- sys_clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rqst_valid  in  1  request vector valid
- rqst_ready  out  1  scheduler can accept a vector
- rqst_in  in  SHARED_GROUP_SIZE  per-requester request bits
- rqst_addr_in  in  SHARED_GROUP_SIZE*ADDR_WIDTH  page addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- issue_stall  in  1  downstream port busy; hold current round
- issue_en  out  SHARED_GROUP_SIZE  requesters issued this cycle
- issue_addr  out  SHARED_GROUP_SIZE*ADDR_WIDTH  addresses, valid where issue_en set, zero elsewhere
- issue_round  out  RND_WIDTH  index of current round, 0-based
- sched_done  out  1  one-cycle pulse: vector fully served

## Operation
- States: IDLE, SCHED.
- IDLE: rqst_ready=1. On rqst_valid&rqst_ready, latch rqst_in into pending mask P and addresses into addr regs; issue_round←0.
  - If rqst_in≠0, go to SCHED.
  - If rqst_in=0, stay IDLE and pulse sched_done next cycle with no issue.
- SCHED: rqst_ready=0. Issue mask M is combinational from P:
  - M[0]=P[0]
  - M[i]=P[i]&~M[i-1]
- Each SCHED cycle with issue_stall=0:
  - Register issue_en←M and issue_addr←masked addresses.
  - P←P&~M; issue_round increments after each issued round.
  - When P&~M=0, return to IDLE and pulse sched_done in the same cycle as the final issue_en.
- issue_stall=1 in SCHED: issue_en←0, P and issue_round unchanged.
- rqst_valid while in SCHED is ignored; upstream holds it.
- Rounds needed equal the longest run of consecutive pending bits, capped at 2. Greedy alternation finishes any vector in at most 2 rounds.
- Requester i is issued only for a bit it requested; each set bit is issued exactly once.

## Timing
- Reset: state=IDLE, P=0, addr regs=0, rqst_ready=1, issue_en=0, issue_addr=0, issue_round=0, sched_done=0.
- Outputs are registered. Accept at cycle T → first issue_en at T+2, since M is evaluated in the first SCHED cycle (T+1) and registered.
- Empty vector accepted at T → sched_done at T+1.
- rqst_ready is low from T+1 until the cycle after sched_done. Back-to-back vectors are spaced by (rounds+2) cycles minimum.
- issue_en, issue_addr and sched_done are single-cycle pulses; no output is held across a stall.
- Reset mid-SCHED: pending requests are discarded and all outputs are at reset values from the reset edge; no sched_done is produced.
- issue_round shows the round just issued while issue_en≠0. It does not wrap for legal sizes.

## Structure
- Shared package: state encoding (IDLE/SCHED), and a function or localparam helper to compute RND_WIDTH from SHARED_GROUP_SIZE.
- Sub-module sched_issue_mask: combinational P→M neighbour-exclusion chain, parameterised by SHARED_GROUP_SIZE. It is reused by the parallel-column variants.
- Top level holds the FSM, the pending/address registers and the output registers.

## Test plan
- rqst_in=4'b1111, addrs 0x10..0x13 → issue_en=0101 at T+2 (addrs 0x10,0x12), 1010 at T+3 (0x11,0x13) with sched_done; issue_round 0 then 1.
- rqst_in=4'b0110 → issue_en=0010 (round 0), then 0100 with sched_done; never 0110 in one cycle.
- rqst_in=4'b1001 → issue_en=1001 at T+2 with sched_done; single round.
- rqst_in=4'b0000 → no issue_en; sched_done at T+1; rqst_ready high again at T+2.
- rqst_in=1111 with issue_stall high for 3 cycles after accept → issue_en=0 during the stall, then 0101, 1010 unchanged; rqst_valid pulses during SCHED are not accepted.
- Assert rst during the second round of 1111 → outputs zero immediately, rqst_ready=1, no sched_done; the next vector 0001 issues normally.
